// File: rtl/adda_sample_fifo.sv
// Mixed-width sample FIFO: 16-bit ADC words in, 8-bit bytes out (low byte first), single clock.
// Latency: a written word is readable the cycle after the write edge; q is valid 1 cycle after an accepted rdreq.
// Backpressure: writes are dropped while wrfull, reads are ignored while rdempty (optional sticky flags via FIFO_ERR_FLAGS_EN).
module adda_sample_fifo #(
  parameter int WR_DEPTH = 256,
  parameter int WR_AW    = 8
) (
  input  logic              mclk,
  input  logic              i_rest_n,
  input  logic [15:0]       data,
  input  logic              wrreq,
  input  logic              rdreq,
  output logic [7:0]        q,
  output logic              rdempty,
  output logic              rdfull,
  output logic [WR_AW+1:0]  rdusedw,
  output logic              wrempty,
  output logic              wrfull,
  output logic [WR_AW:0]    wrusedw
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              wr_ovf,
  output logic              rd_udf
`endif
);

  localparam int BYTES = 2 * WR_DEPTH;
  localparam int FULLW = BYTES - 1;
  localparam logic [WR_AW+1:0] CAP      = BYTES[WR_AW+1:0];
  // A word needs two free bytes, so one free byte still counts as full.
  localparam logic [WR_AW+1:0] WR_LIMIT = FULLW[WR_AW+1:0];

  logic [7:0]       mem [BYTES];
  logic [WR_AW:0]   wptr;
  logic [WR_AW:0]   wptr_odd;
  logic [WR_AW:0]   rptr;
  logic [WR_AW+1:0] cnt;
  logic [WR_AW+1:0] cnt_nxt;
  logic [WR_AW+1:0] cnt_rnd;
  logic             wr_acc;
  logic             rd_acc;
  logic             empty_q;

  // Acceptance uses only the registered flags, so a same-cycle opposite
  // operation can never rescue a rejected request.
  always_comb begin
    wr_acc  = wrreq && !wrfull;
    rd_acc  = rdreq && !empty_q;
    cnt_nxt = cnt;
    if (wr_acc) cnt_nxt = cnt_nxt + (WR_AW+2)'(2);
    if (rd_acc) cnt_nxt = cnt_nxt - (WR_AW+2)'(1);
    // Round up so an odd leftover byte still occupies one word.
    cnt_rnd = cnt_nxt + (WR_AW+2)'(1);
  end

  // wptr is always even, so the high byte of a word lands at wptr|1.
  assign wptr_odd = wptr + (WR_AW+1)'(1);

  // Byte storage; contents are not cleared by reset, pointers make them stale.
  always_ff @(posedge mclk) begin
    if (wr_acc) begin
      mem[wptr]     <= data[7:0];
      mem[wptr_odd] <= data[15:8];
    end
  end

  // Pointers, byte count, registered read data and all status flags.
  always_ff @(posedge mclk) begin
    if (!i_rest_n) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      q       <= '0;
      empty_q <= 1'b1;
      rdfull  <= 1'b0;
      wrfull  <= 1'b0;
      wrusedw <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + (WR_AW+1)'(2);
      if (rd_acc) begin
        q    <= mem[rptr];
        rptr <= rptr + (WR_AW+1)'(1);
      end
      cnt     <= cnt_nxt;
      empty_q <= (cnt_nxt == '0);
      rdfull  <= (cnt_nxt == CAP);
      wrfull  <= (cnt_nxt >= WR_LIMIT);
      wrusedw <= cnt_rnd[WR_AW+1:1];
    end
  end

  assign rdusedw = cnt;
  assign rdempty = empty_q;
  assign wrempty = empty_q;

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky overflow/underflow indicators, cleared only by reset.
  always_ff @(posedge mclk) begin
    if (!i_rest_n) begin
      wr_ovf <= 1'b0;
      rd_udf <= 1'b0;
    end else begin
      if (wrreq && wrfull)  wr_ovf <= 1'b1;
      if (rdreq && empty_q) rd_udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adda_sample_fifo.sv
// Directed bench for adda_sample_fifo: reset, word/byte ordering, full/empty edges,
// concurrent read/write across the pointer wrap, and mid-stream reset.
module tb_adda_sample_fifo;

  logic        mclk;
  logic        i_rest_n;
  logic [15:0] data;
  logic        wrreq;
  logic        rdreq;
  logic [7:0]  q;
  logic        rdempty;
  logic        rdfull;
  logic [9:0]  rdusedw;
  logic        wrempty;
  logic        wrfull;
  logic [8:0]  wrusedw;
`ifdef FIFO_ERR_FLAGS_EN
  logic        wr_ovf;
  logic        rd_udf;
`endif

  int checks   = 0;
  int failures = 0;

  adda_sample_fifo #(.WR_DEPTH(256), .WR_AW(8)) dut (
    .mclk     (mclk),
    .i_rest_n (i_rest_n),
    .data     (data),
    .wrreq    (wrreq),
    .rdreq    (rdreq),
    .q        (q),
    .rdempty  (rdempty),
    .rdfull   (rdfull),
    .rdusedw  (rdusedw),
    .wrempty  (wrempty),
    .wrfull   (wrfull),
    .wrusedw  (wrusedw)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .wr_ovf   (wr_ovf),
    .rd_udf   (rd_udf)
`endif
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Byte n of a stream of words base+1, base+2, ... in low-byte-first order.
  function automatic logic [7:0] stream_byte(input logic [15:0] base, input int n);
    logic [15:0] w;
    w = base + 16'(n / 2 + 1);
    return (n % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  logic [7:0] t4_exp [10] = '{8'h11, 8'h22, 8'h51, 8'hA1, 8'h52,
                              8'hA2, 8'h53, 8'hA3, 8'h54, 8'hA4};

  initial begin
    i_rest_n = 1'b0;
    data     = 16'h0000;
    wrreq    = 1'b0;
    rdreq    = 1'b0;
    step();
    step();

    // Reset state
    check("rst_q",       q,       32'h0);
    check("rst_rdempty", rdempty, 32'h1);
    check("rst_wrempty", wrempty, 32'h1);
    check("rst_rdfull",  rdfull,  32'h0);
    check("rst_wrfull",  wrfull,  32'h0);
    check("rst_rdusedw", rdusedw, 32'h0);
    check("rst_wrusedw", wrusedw, 32'h0);
`ifdef FIFO_ERR_FLAGS_EN
    check("rst_wr_ovf", wr_ovf, 32'h0);
    check("rst_rd_udf", rd_udf, 32'h0);
`endif
    i_rest_n = 1'b1;
    step();

    // 1: single word, low byte first
    data  = 16'hA55A;
    wrreq = 1'b1;
    step();
    wrreq = 1'b0;
    check("t1_rdusedw", rdusedw, 32'd2);
    check("t1_wrusedw", wrusedw, 32'd1);
    check("t1_rdempty", rdempty, 32'h0);
    check("t1_wrempty", wrempty, 32'h0);
    rdreq = 1'b1;
    step();
    check("t1_q_lo", q, 32'h5A);
    check("t1_wrusedw_odd", wrusedw, 32'd1);
    step();
    rdreq = 1'b0;
    check("t1_q_hi",     q,       32'hA5);
    check("t1_rdempty2", rdempty, 32'h1);
    check("t1_rdusedw2", rdusedw, 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("t1_rd_udf", rd_udf, 32'h0);
`endif

    // 2: fill to capacity, overflow drop, full drain
    wrreq = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      data = 16'(i);
      step();
    end
    wrreq = 1'b0;
    check("t2_wrfull",  wrfull,  32'h1);
    check("t2_rdfull",  rdfull,  32'h1);
    check("t2_rdusedw", rdusedw, 32'd512);
    check("t2_wrusedw", wrusedw, 32'd256);
    data  = 16'hFFFF;
    wrreq = 1'b1;
    step();
    wrreq = 1'b0;
    check("t2_ovf_rdusedw", rdusedw, 32'd512);
`ifdef FIFO_ERR_FLAGS_EN
    check("t2_wr_ovf", wr_ovf, 32'h1);
`endif
    rdreq = 1'b1;
    for (int j = 0; j < 512; j++) begin
      step();
      check("t2_drain_q", q, stream_byte(16'h0000, j));
    end
    rdreq = 1'b0;
    check("t2_rdempty", rdempty, 32'h1);

    // 3: one free byte is still full
    wrreq = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      data = 16'h1000 + 16'(i);
      step();
    end
    wrreq = 1'b0;
    rdreq = 1'b1;
    step();
    rdreq = 1'b0;
    check("t3_q0",       q,       32'h01);
    check("t3_rdusedw1", rdusedw, 32'd511);
    check("t3_wrfull1",  wrfull,  32'h1);
    check("t3_rdfull1",  rdfull,  32'h0);
    data  = 16'hBEEF;
    wrreq = 1'b1;
    step();
    check("t3_rej_rdusedw", rdusedw, 32'd511);
    check("t3_rej_wrusedw", wrusedw, 32'd256);
    check("t3_rej_wrfull",  wrfull,  32'h1);
    rdreq = 1'b1;
    step();
    rdreq = 1'b0;
    check("t3_rd_only_rdusedw", rdusedw, 32'd510);
    check("t3_rd_only_q",       q,       32'h10);
    check("t3_wrfull2",         wrfull,  32'h0);
    step();
    wrreq = 1'b0;
    check("t3_acc_rdusedw", rdusedw, 32'd512);
    check("t3_acc_wrfull",  wrfull,  32'h1);
    rdreq = 1'b1;
    for (int j = 0; j < 512; j++) begin
      step();
      if (j < 510) check("t3_drain_q", q, stream_byte(16'h1000, j + 2));
      else if (j == 510) check("t3_drain_q_ef", q, 32'hEF);
      else check("t3_drain_q_be", q, 32'hBE);
    end
    rdreq = 1'b0;
    check("t3_rdempty", rdempty, 32'h1);

    // 4: move pointers to the top of the buffer, then stream concurrently across the wrap
    wrreq = 1'b1;
    for (int i = 0; i < 253; i++) begin
      data = 16'(i);
      step();
    end
    wrreq = 1'b0;
    rdreq = 1'b1;
    for (int j = 0; j < 506; j++) step();
    rdreq = 1'b0;
    data  = 16'h2211;
    wrreq = 1'b1;
    step();
    check("t4_start_rdusedw", rdusedw, 32'd2);
    rdreq = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      data = {8'(8'hA0 + c), 8'(8'h50 + c)};
      step();
      check("t4_conc_rdusedw", rdusedw, 32'(2 + c));
      check("t4_conc_q",       q,       32'(t4_exp[c-1]));
    end
    wrreq = 1'b0;
    check("t4_rdusedw12", rdusedw, 32'd12);
    for (int n = 0; n < 12; n++) begin
      step();
      check("t4_tail_q", q, (n % 2 == 1) ? 32'(8'hA0 + 5 + n / 2) : 32'(8'h50 + 5 + n / 2));
    end
    rdreq = 1'b0;
    check("t4_rdempty", rdempty, 32'h1);

    // 5: read while empty, then read+write on the empty edge
    rdreq = 1'b1;
    step();
    rdreq = 1'b0;
    check("t5_hold_q",   q,       32'hAA);
    check("t5_rdusedw",  rdusedw, 32'd0);
    check("t5_wrusedw",  wrusedw, 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("t5_rd_udf", rd_udf, 32'h1);
`endif
    data  = 16'h7788;
    wrreq = 1'b1;
    rdreq = 1'b1;
    step();
    wrreq = 1'b0;
    rdreq = 1'b0;
    check("t5_wo_rdusedw", rdusedw, 32'd2);
    check("t5_wo_q",       q,       32'hAA);
    rdreq = 1'b1;
    step();
    check("t5_q_lo",     q,       32'h88);
    check("t5_odd_wrusedw", wrusedw, 32'd1);
    check("t5_odd_rdusedw", rdusedw, 32'd1);
    step();
    rdreq = 1'b0;
    check("t5_q_hi", q, 32'h77);

    // 6: reset with 100 bytes stored
    wrreq = 1'b1;
    for (int i = 0; i < 50; i++) begin
      data = 16'h3000 + 16'(i);
      step();
    end
    wrreq = 1'b0;
    check("t6_pre_rdusedw", rdusedw, 32'd100);
    i_rest_n = 1'b0;
    step();
    i_rest_n = 1'b1;
    check("t6_rdusedw", rdusedw, 32'd0);
    check("t6_wrusedw", wrusedw, 32'd0);
    check("t6_rdempty", rdempty, 32'h1);
    check("t6_q",       q,       32'h0);
`ifdef FIFO_ERR_FLAGS_EN
    check("t6_wr_ovf", wr_ovf, 32'h0);
    check("t6_rd_udf", rd_udf, 32'h0);
`endif
    data  = 16'hC3D4;
    wrreq = 1'b1;
    step();
    wrreq = 1'b0;
    check("t6_rt_rdusedw", rdusedw, 32'd2);
    rdreq = 1'b1;
    step();
    check("t6_rt_q_lo", q, 32'hD4);
    step();
    rdreq = 1'b0;
    check("t6_rt_q_hi",    q,       32'hC3);
    check("t6_rt_rdempty", rdempty, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
